// File: rtl/reg_wb_arbiter.sv
// ============================================================================
// Module   : reg_wb_arbiter
// Purpose  : Register-file write-port owner: post-reset clear sweep, then
//            dbg-priority / ALU-MEM round-robin writeback arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wb_arbiter #(
  parameter int              NREG       = 32,
  parameter int              AW         = 5,
  parameter int              DW         = 32,
  parameter logic [DW-1:0]   INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  input  logic          dbg_valid,
  input  logic [AW-1:0] dbg_reg,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_reg,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          RegWrite,
  output logic [AW-1:0] Write_Reg,
  output logic [DW-1:0] Write_Data,
  output logic          init_done
);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic [0:0] {GNT_ALU = 1'b0, GNT_MEM = 1'b1} gnt_t;

  localparam logic [AW-1:0] c_last_reg = AW'(NREG - 1);

  state_t        r_fsm;
  logic [AW-1:0] r_ptr;
  gnt_t          r_last_grant;
  logic          r_init_done;

  logic w_dbg_nz, w_alu_nz, w_mem_nz;
  logic w_dbg_zero, w_alu_zero, w_mem_zero;
  logic w_run;
  logic w_gnt_dbg, w_gnt_alu, w_gnt_mem;

  assign w_run      = (r_fsm == ST_RUN) && !rst;

  assign w_dbg_nz   = dbg_valid && (dbg_reg != '0);
  assign w_alu_nz   = alu_valid && (alu_reg != '0);
  assign w_mem_nz   = mem_valid && (mem_reg != '0);
  assign w_dbg_zero = dbg_valid && (dbg_reg == '0);
  assign w_alu_zero = alu_valid && (alu_reg == '0);
  assign w_mem_zero = mem_valid && (mem_reg == '0);

  // On an ALU/MEM tie the side that did not win last time takes the slot.
  assign w_gnt_dbg  = w_run && w_dbg_nz;
  assign w_gnt_alu  = w_run && !w_dbg_nz && w_alu_nz &&
                      (!w_mem_nz || (r_last_grant == GNT_MEM));
  assign w_gnt_mem  = w_run && !w_dbg_nz && w_mem_nz &&
                      (!w_alu_nz || (r_last_grant == GNT_ALU));

  always_comb begin
    dbg_ready  = 1'b0;
    alu_ready  = 1'b0;
    mem_ready  = 1'b0;
    RegWrite   = 1'b0;
    Write_Reg  = '0;
    Write_Data = '0;
    if (!rst) begin
      if (r_fsm == ST_CLEAR) begin
        RegWrite   = 1'b1;
        Write_Reg  = r_ptr;
        Write_Data = INIT_VALUE;
      end else begin
        // Writes to register 0 are acknowledged and dropped.
        dbg_ready = w_gnt_dbg || w_dbg_zero;
        alu_ready = w_gnt_alu || w_alu_zero;
        mem_ready = w_gnt_mem || w_mem_zero;
        if (w_gnt_dbg) begin
          RegWrite   = 1'b1;
          Write_Reg  = dbg_reg;
          Write_Data = dbg_data;
        end else if (w_gnt_alu) begin
          RegWrite   = 1'b1;
          Write_Reg  = alu_reg;
          Write_Data = alu_data;
        end else if (w_gnt_mem) begin
          RegWrite   = 1'b1;
          Write_Reg  = mem_reg;
          Write_Data = mem_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm        <= ST_CLEAR;
      r_ptr        <= '0;
      r_last_grant <= GNT_MEM;
      r_init_done  <= 1'b0;
    end else begin
      case (r_fsm)
        ST_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == c_last_reg) begin
            r_fsm       <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          if (w_gnt_alu) r_last_grant <= GNT_ALU;
          if (w_gnt_mem) r_last_grant <= GNT_MEM;
          if (clear_req) begin
            r_fsm       <= ST_CLEAR;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
          end
        end
      endcase
    end
  end

  assign init_done = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// ============================================================================
// Module   : tb_reg_wb_arbiter
// Purpose  : Directed self-checking bench for reg_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_req;
  logic          dbg_valid, alu_valid, mem_valid;
  logic [AW-1:0] dbg_reg, alu_reg, mem_reg;
  logic [DW-1:0] dbg_data, alu_data, mem_data;
  logic          dbg_ready, alu_ready, mem_ready;
  logic          RegWrite;
  logic [AW-1:0] Write_Reg;
  logic [DW-1:0] Write_Data;
  logic          init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.NREG(32), .AW(AW), .DW(DW), .INIT_VALUE('0)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .dbg_valid(dbg_valid), .dbg_reg(dbg_reg), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Data(Write_Data),
    .init_done(init_done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    clear_req = 1'b0;
    dbg_valid = 1'b0; dbg_reg = '0; dbg_data = '0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
  endtask

  // Inputs change just after a negedge; outputs are sampled 1 time unit later.
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    dbg_valid = 1'b1; dbg_reg = 5'd7; dbg_data = 32'h1;
    @(negedge clk); #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data, init_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b%b%b we=%b reg=%0d data=%h done=%b, required all 0",
               dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data, init_done);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (RegWrite !== 1'b1 || Write_Reg !== AW'(i) || Write_Data !== 32'h0 ||
          {dbg_ready, alu_ready, mem_ready} !== 3'b000 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep[%0d]: we=%b reg=%0d data=%h rdy=%b%b%b done=%b, required we=1 reg=%0d data=0 rdy=000 done=0",
                 i, RegWrite, Write_Reg, Write_Data, dbg_ready, alu_ready, mem_ready, init_done, i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (init_done !== 1'b1 || RegWrite !== 1'b0 || Write_Reg !== '0 || Write_Data !== '0) begin
      errors++;
      $display("FAIL reset_run_idle: done=%b we=%b reg=%0d data=%h, required done=1 we=0 reg=0 data=0",
               init_done, RegWrite, Write_Reg, Write_Data);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic exp_alu;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hAAAA0001;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'hBBBB0002;
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      #1;
      checks++;
      if (alu_ready !== exp_alu || mem_ready !== !exp_alu || dbg_ready !== 1'b0 || RegWrite !== 1'b1 ||
          Write_Reg !== (exp_alu ? 5'd3 : 5'd4) ||
          Write_Data !== (exp_alu ? 32'hAAAA0001 : 32'hBBBB0002)) begin
        errors++;
        $display("FAIL round_robin[%0d]: alu_rdy=%b mem_rdy=%b we=%b reg=%0d data=%h, required alu_rdy=%b mem_rdy=%b reg=%0d",
                 i, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data, exp_alu, !exp_alu,
                 exp_alu ? 3 : 4);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_dbg_zero();
    dbg_valid = 1'b1; dbg_reg = 5'd7; dbg_data = 32'h12345678;
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hDEAD0000;
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h99990009;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b110 || RegWrite !== 1'b1 ||
        Write_Reg !== 5'd7 || Write_Data !== 32'h12345678) begin
      errors++;
      $display("FAIL dbg_zero: rdy=%b%b%b we=%b reg=%0d data=%h, required rdy=110 we=1 reg=7 data=12345678",
               dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data);
    end
    @(negedge clk);
    dbg_valid = 1'b0; alu_valid = 1'b0;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b001 || RegWrite !== 1'b1 ||
        Write_Reg !== 5'd9 || Write_Data !== 32'h99990009) begin
      errors++;
      $display("FAIL dbg_then_mem: rdy=%b%b%b we=%b reg=%0d data=%h, required rdy=001 we=1 reg=9 data=99990009",
               dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_single_mem();
    mem_valid = 1'b1; mem_reg = 5'd31; mem_data = 32'h3131_3131;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b001 || RegWrite !== 1'b1 ||
        Write_Reg !== 5'd31 || Write_Data !== 32'h3131_3131) begin
      errors++;
      $display("FAIL single_mem: rdy=%b%b%b we=%b reg=%0d data=%h, required rdy=001 we=1 reg=31 data=31313131",
               dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_absorb();
    // All three target r0: all accepted together, nothing written.
    dbg_valid = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
    dbg_data = 32'h1; alu_data = 32'h2; mem_data = 32'h3;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b111 || RegWrite !== 1'b0 ||
        Write_Reg !== '0 || Write_Data !== '0) begin
      errors++;
      $display("FAIL absorb_all: rdy=%b%b%b we=%b reg=%0d data=%h, required rdy=111 we=0 reg=0 data=0",
               dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data);
    end
    @(negedge clk);
    dbg_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    // Absorbed ALU requests must not have moved the round-robin pointer.
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA3;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'hB4;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b010 || Write_Reg !== 5'd3 || Write_Data !== 32'hA3) begin
      errors++;
      $display("FAIL absorb_keeps_rr: rdy=%b%b%b reg=%0d data=%h, required rdy=010 reg=3 data=a3",
               dbg_ready, alu_ready, mem_ready, Write_Reg, Write_Data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    dbg_valid = 1'b1; dbg_reg = 5'd12; dbg_data = 32'hD12;
    alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'hA10;
    mem_valid = 1'b1; mem_reg = 5'd10; mem_data = 32'hB10;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b100 || Write_Reg !== 5'd12 || Write_Data !== 32'hD12) begin
      errors++;
      $display("FAIL b2b_dbg: rdy=%b%b%b reg=%0d data=%h, required rdy=100 reg=12 data=d12",
               dbg_ready, alu_ready, mem_ready, Write_Reg, Write_Data);
    end
    @(negedge clk);
    dbg_valid = 1'b0;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b001 || Write_Reg !== 5'd10 || Write_Data !== 32'hB10) begin
      errors++;
      $display("FAIL b2b_mem: rdy=%b%b%b reg=%0d data=%h, required rdy=001 reg=10 data=b10",
               dbg_ready, alu_ready, mem_ready, Write_Reg, Write_Data);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready} !== 3'b010 || Write_Reg !== 5'd10 || Write_Data !== 32'hA10) begin
      errors++;
      $display("FAIL b2b_alu_last: rdy=%b%b%b reg=%0d data=%h, required rdy=010 reg=10 data=a10",
               dbg_ready, alu_ready, mem_ready, Write_Reg, Write_Data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_clear_req();
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h55;
    clear_req = 1'b1;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || RegWrite !== 1'b1 || Write_Reg !== 5'd5 || Write_Data !== 32'h55 ||
        init_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_req_cycle: alu_rdy=%b we=%b reg=%0d data=%h done=%b, required 1 1 5 55 1",
               alu_ready, RegWrite, Write_Reg, Write_Data, init_done);
    end
    @(negedge clk);
    clear_req = 1'b0; alu_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k >= 10) begin
        alu_valid = 1'b1; alu_reg = 5'd6; alu_data = 32'h66;
      end
      #1;
      checks++;
      if (init_done !== 1'b0 || RegWrite !== 1'b1 || Write_Reg !== AW'(k) || Write_Data !== 32'h0 ||
          {dbg_ready, alu_ready, mem_ready} !== 3'b000) begin
        errors++;
        $display("FAIL clear_sweep[%0d]: done=%b we=%b reg=%0d data=%h rdy=%b%b%b, required done=0 we=1 reg=%0d data=0 rdy=000",
                 k, init_done, RegWrite, Write_Reg, Write_Data, dbg_ready, alu_ready, mem_ready, k);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (init_done !== 1'b1 || alu_ready !== 1'b1 || RegWrite !== 1'b1 ||
        Write_Reg !== 5'd6 || Write_Data !== 32'h66) begin
      errors++;
      $display("FAIL clear_first_run: done=%b alu_rdy=%b we=%b reg=%0d data=%h, required 1 1 1 6 66",
               init_done, alu_ready, RegWrite, Write_Reg, Write_Data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    checks++;
    if (Write_Reg !== 5'd17 || RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_ptr: we=%b reg=%0d, required we=1 reg=17", RegWrite, Write_Reg);
    end
    rst = 1'b1;
    alu_valid = 1'b1; alu_reg = 5'd8; alu_data = 32'h88;
    #1;
    checks++;
    if ({dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data} !== '0) begin
      errors++;
      $display("FAIL mid_sweep_rst_outputs: rdy=%b%b%b we=%b reg=%0d data=%h, required all 0",
               dbg_ready, alu_ready, mem_ready, RegWrite, Write_Reg, Write_Data);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (RegWrite !== 1'b1 || Write_Reg !== AW'(k) || init_done !== 1'b0) begin
        errors++;
        $display("FAIL restart_sweep[%0d]: we=%b reg=%0d done=%b, required we=1 reg=%0d done=0",
                 k, RegWrite, Write_Reg, init_done, k);
      end
      @(negedge clk);
    end
    // Reset returns last_grant to MEM, so ALU wins this tie.
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA3;
    mem_valid = 1'b1; mem_reg = 5'd4; mem_data = 32'hB4;
    #1;
    checks++;
    if (init_done !== 1'b1 || {dbg_ready, alu_ready, mem_ready} !== 3'b010 || Write_Reg !== 5'd3) begin
      errors++;
      $display("FAIL tie_after_reset: done=%b rdy=%b%b%b reg=%0d, required done=1 rdy=010 reg=3",
               init_done, dbg_ready, alu_ready, mem_ready, Write_Reg);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_dbg_zero();
    test_single_mem();
    test_absorb();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
